// File: rtl/cgra_cfg_pkg.sv
// Shared types and word-format constants for the CGRA configuration loader.
package cgra_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } loader_state_e;

    localparam int unsigned CFG_WORD_BYTES = 8;
    localparam int unsigned PE_ID_MSB      = 63;
    localparam int unsigned PE_ID_LSB      = 58;
    localparam int unsigned PAYLOAD_MSB    = 57;

endpackage

// File: rtl/cgra_cfg_fifo.sv
// Small synchronous return-word FIFO with flush; DEPTH must be a power of 2.
module cgra_cfg_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];

    // NOTE: give every always_comb output a default first, otherwise an untaken branch infers a latch.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    // NOTE: storage is not reset; the count/pointers alone decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/cgra_config_loader.sv
// Streams a block of config words from config memory to the PE config bus.
// Optional even-parity check of returned words: define CGRA_CFG_PARITY_EN.
module cgra_config_loader
    import cgra_cfg_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned PE_ID_WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [CNT_WIDTH-1:0]   num_words,
    output logic [ADDR_WIDTH-1:0]  cfg_addr,
    output logic                   cfg_ren,
    input  logic [DATA_WIDTH-1:0]  cfg_rdata,
    input  logic                   cfg_valid,
    output logic                   pe_cfg_valid,
    input  logic                   pe_cfg_ready,
    output logic [PE_ID_WIDTH-1:0] pe_cfg_id,
    output logic [57:0]            pe_cfg_data,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_WIDTH-1:0]   words_sent
`ifdef CGRA_CFG_PARITY_EN
    ,
    output logic                   parity_err,
    output logic [ADDR_WIDTH-1:0]  err_addr
`endif
);

    localparam int unsigned FC_W = $clog2(FIFO_DEPTH) + 1;

    loader_state_e         state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
    logic [CNT_WIDTH-1:0]  words_sent_q, words_sent_d;
    logic                  outstanding_q, outstanding_d;
    logic                  abort_q, abort_d;

    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic [FC_W-1:0]       fifo_count;
    logic                  fifo_empty, fifo_full;
    logic                  credit_ok, rd_fire, ret_fire, word_ok, par_fail;
    logic                  push, xfer, in_load, abort_go, start_ok;

    // Credits count buffered words plus the one possibly in flight, so a return always fits.
    assign credit_ok = (fifo_count + FC_W'(outstanding_q)) < FC_W'(FIFO_DEPTH);
    assign rd_fire   = (state_q == FETCH) && !abort_q && (remaining_q != '0) && credit_ok;
    assign ret_fire  = cfg_valid && outstanding_q;
`ifdef CGRA_CFG_PARITY_EN
    assign word_ok   = ~^cfg_rdata;
`else
    assign word_ok   = 1'b1;
`endif
    assign par_fail  = ret_fire && !word_ok && !abort_q;
    assign push      = ret_fire && word_ok && !abort_q;
    assign in_load   = (state_q == FETCH) || (state_q == DRAIN);
    assign abort_go  = in_load && !abort_q && (abort || par_fail);
    assign start_ok  = (state_q == IDLE) && start;

    // The head is hidden while aborting so no word slips out of a flushed buffer.
    assign pe_cfg_valid = !fifo_empty && !abort_q;
    assign xfer         = pe_cfg_valid && pe_cfg_ready;
    assign pe_cfg_id    = fifo_rdata[PE_ID_MSB:PE_ID_LSB];
    assign pe_cfg_data  = fifo_rdata[PAYLOAD_MSB:0];

    assign cfg_ren    = rd_fire;
    assign cfg_addr   = addr_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign words_sent = words_sent_q;

    cgra_cfg_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (abort_q),
        .push  (push),
        .wdata (cfg_rdata),
        .pop   (xfer),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        remaining_d   = remaining_q;
        abort_d       = abort_q;
        words_sent_d  = words_sent_q + CNT_WIDTH'(xfer);
        outstanding_d = rd_fire ? 1'b1 : (cfg_valid ? 1'b0 : outstanding_q);

        if (rd_fire) begin
            addr_d      = addr_q + ADDR_WIDTH'(CFG_WORD_BYTES);
            remaining_d = remaining_q - CNT_WIDTH'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    words_sent_d = '0;
                    if (num_words != '0) begin
                        addr_d      = {base_addr[ADDR_WIDTH-1:3], 3'b000};
                        remaining_d = num_words;
                        state_d     = FETCH;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            FETCH: begin
                if (!abort_q && !abort_go && remaining_d == '0) state_d = DRAIN;
            end
            DRAIN: begin
                if (!abort_q && !abort_go && !outstanding_q && fifo_empty) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (abort_go) abort_d = 1'b1;
        // The flush cycle ends only once the dropped return has come back.
        if (abort_q && !outstanding_d) begin
            abort_d = 1'b0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            remaining_q   <= '0;
            words_sent_q  <= '0;
            outstanding_q <= 1'b0;
            abort_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            remaining_q   <= remaining_d;
            words_sent_q  <= words_sent_d;
            outstanding_q <= outstanding_d;
            abort_q       <= abort_d;
        end
    end

`ifdef CGRA_CFG_PARITY_EN
    logic                  parity_err_q;
    logic [ADDR_WIDTH-1:0] err_addr_q;

    // With one read in flight, the returning word sits one word behind addr_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err_q <= 1'b0;
            err_addr_q   <= '0;
        end else if (start_ok) begin
            parity_err_q <= 1'b0;
        end else if (par_fail) begin
            parity_err_q <= 1'b1;
            err_addr_q   <= addr_q - ADDR_WIDTH'(CFG_WORD_BYTES);
        end
    end

    assign parity_err = parity_err_q;
    assign err_addr   = err_addr_q;
`endif

endmodule

// File: tb/tb_cgra_config_loader.sv
// Bench for cgra_config_loader: transaction-level model plus directed and random loads.
// Also covers the parity path when CGRA_CFG_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_cgra_config_loader;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort;
    logic [31:0] base_addr;
    logic [15:0] num_words;
    logic [31:0] cfg_addr;
    logic        cfg_ren;
    logic [63:0] cfg_rdata;
    logic        cfg_valid;
    logic        pe_cfg_valid, pe_cfg_ready;
    logic [5:0]  pe_cfg_id;
    logic [57:0] pe_cfg_data;
    logic        busy, done;
    logic [15:0] words_sent;
`ifdef CGRA_CFG_PARITY_EN
    logic        parity_err;
    logic [31:0] err_addr;
`endif

    always #5 clk = ~clk;

    cgra_config_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .base_addr    (base_addr),
        .num_words    (num_words),
        .cfg_addr     (cfg_addr),
        .cfg_ren      (cfg_ren),
        .cfg_rdata    (cfg_rdata),
        .cfg_valid    (cfg_valid),
        .pe_cfg_valid (pe_cfg_valid),
        .pe_cfg_ready (pe_cfg_ready),
        .pe_cfg_id    (pe_cfg_id),
        .pe_cfg_data  (pe_cfg_data),
        .busy         (busy),
        .done         (done),
        .words_sent   (words_sent)
`ifdef CGRA_CFG_PARITY_EN
        ,
        .parity_err   (parity_err),
        .err_addr     (err_addr)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory image: address-derived pattern, forced to even parity.
    function automatic logic [63:0] mem_word(input logic [31:0] a);
        logic [63:0] w;
        w = {a * 32'h9E37_79B1, a ^ 32'h5A5A_1234};
        if (^w) w[0] = ~w[0];
        return w;
    endfunction

    // ---------------- memory responder: one-cycle read latency ----------------
    logic        ren_s;
    logic [31:0] raddr_s;
    logic        bad_en = 1'b0;
    logic [31:0] bad_addr = '0;

    always @(negedge clk) begin
        ren_s   = rst_n && cfg_ren;
        raddr_s = cfg_addr;
    end

    initial begin
        cfg_valid = 1'b0;
        cfg_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            cfg_valid = ren_s;
            cfg_rdata = mem_word(raddr_s);
            if (bad_en && raddr_s == bad_addr) cfg_rdata = cfg_rdata ^ 64'h2;
        end
    end

    // ---------------- PE-side ready driver ----------------
    int ready_mode = 1;
    initial begin
        pe_cfg_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       pe_cfg_ready = 1'b0;
                1:       pe_cfg_ready = 1'b1;
                default: pe_cfg_ready = ($urandom_range(0, 9) < 7);
            endcase
        end
    end

    // ---------------- model state and per-load logs ----------------
    int          cyc = 0;
    bit          active, aborted, done_next, prev_hold, ret_pending;
    int          num_l, reads_l, deliv, abort_age;
    logic [31:0] exp_addr, last_rd_addr;
    logic [63:0] exp_q[$];
    logic [63:0] prev_word;
    logic [31:0] ren_log[$];
    int          ren_cyc[$];
    int          start_cyc, first_valid_cyc, done_cyc, done_cnt;
    bit          exp_perr;
    logic [31:0] exp_eaddr;

    always @(posedge clk) cyc++;

    // ---------------- compare process ----------------
    initial begin
        active = 0; aborted = 0; done_next = 0; prev_hold = 0; ret_pending = 0;
        num_l = 0; reads_l = 0; deliv = 0; abort_age = 0; exp_perr = 0;
        exp_eaddr = '0; last_rd_addr = '0; exp_addr = '0; prev_word = '0;
        start_cyc = 0; first_valid_cyc = -1; done_cyc = -1; done_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("reset_outputs", {cfg_addr, cfg_ren, pe_cfg_valid, busy, done, words_sent}, '0);
                active = 0; aborted = 0; done_next = 0; prev_hold = 0; ret_pending = 0;
                deliv = 0; exp_q.delete(); exp_perr = 0;
            end else begin
                if (cfg_ren) begin
                    check("ren_legal", {active, aborted, reads_l < num_l}, 3'b101);
                    check("ren_addr", cfg_addr, exp_addr);
                    check("ren_credit", (reads_l - deliv) < DEPTH, 1);
                    ren_log.push_back(cfg_addr);
                    ren_cyc.push_back(cyc);
                    reads_l++;
                    exp_addr = exp_addr + 32'd8;
                end
                if (pe_cfg_valid) begin
                    check("valid_legal", {active, aborted}, 2'b10);
                    if (first_valid_cyc < 0) first_valid_cyc = cyc;
                end
                if (prev_hold) begin
                    check("hold_valid", pe_cfg_valid, 1);
                    check("hold_word", {pe_cfg_id, pe_cfg_data}, prev_word);
                end
                check("words_sent", words_sent, deliv);
                if (!aborted) check("busy", busy, active);
                if (pe_cfg_valid && pe_cfg_ready) begin
                    if (exp_q.size() == 0) check("word_count", deliv + 1, num_l);
                    else check("pe_word", {pe_cfg_id, pe_cfg_data}, exp_q.pop_front());
                    deliv++;
                end
                if (done_next) check("zero_done", done, 1);
                done_next = 0;
                if (done) begin
                    check("done_legal", {active, aborted}, 2'b10);
                    check("done_words", words_sent, num_l);
                    check("done_all", exp_q.size(), 0);
                    done_cnt++;
                    done_cyc = cyc;
                    active = 0;
                end
`ifdef CGRA_CFG_PARITY_EN
                check("parity_err", parity_err, exp_perr);
                if (exp_perr) check("err_addr", err_addr, exp_eaddr);
                if (cfg_valid && ret_pending && active && !aborted && (^cfg_rdata)) begin
                    aborted   = 1;
                    abort_age = 0;
                    exp_perr  = 1;
                    exp_eaddr = last_rd_addr;
                end
`endif
                prev_hold = pe_cfg_valid && !pe_cfg_ready;
                prev_word = {pe_cfg_id, pe_cfg_data};
                ret_pending = cfg_ren;
                if (cfg_ren) last_rd_addr = cfg_addr;
                if (abort && busy && !done && active && !aborted) begin
                    aborted   = 1;
                    abort_age = 0;
                end
                if (aborted) prev_hold = 0;
                if (aborted && !busy) begin
                    aborted = 0;
                    active  = 0;
                end else if (aborted) begin
                    abort_age++;
                    if (abort_age == 5) check("abort_exit", busy, 0);
                end
                if (start && !busy) begin
                    active = 1; aborted = 0; exp_perr = 0;
                    num_l = int'(num_words); reads_l = 0; deliv = 0;
                    exp_addr = {base_addr[31:3], 3'b000};
                    exp_q.delete();
                    for (int i = 0; i < num_l; i++) exp_q.push_back(mem_word(exp_addr + 32'(8 * i)));
                    done_next = (num_words == 0);
                    start_cyc = cyc; first_valid_cyc = -1; done_cyc = -1; done_cnt = 0;
                    ren_log.delete(); ren_cyc.delete();
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_start(input logic [31:0] b, input logic [15:0] n);
        @(posedge clk);
        #1;
        base_addr = b;
        num_words = n;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        @(negedge clk);
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (busy) check("idle_timeout", busy, 0);
        #1;
    endtask

    logic [31:0] exp_basic [4] = '{32'h100, 32'h108, 32'h110, 32'h118};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] b;
        logic [15:0] n;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0; num_words = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_state", {cfg_addr, cfg_ren, pe_cfg_valid, busy, done, words_sent}, '0);

        // Basic 4-word load at 0x100.
        ready_mode = 1;
        do_start(32'h100, 16'd4);
        wait_idle(50);
        check("basic_nreads", ren_log.size(), 4);
        if (ren_log.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("basic_addr", ren_log[i], exp_basic[i]);
                check("basic_ren_cycle", ren_cyc[i] - start_cyc, i + 1);
            end
        end
        check("basic_first_valid", first_valid_cyc - start_cyc, 3);
        check("basic_done_cnt", done_cnt, 1);
        check("basic_words_sent", words_sent, 4);
        check("basic_deliv", deliv, 4);

        // Backpressure: ready held low, reads must stop at FIFO_DEPTH.
        ready_mode = 0;
        do_start(32'h400, 16'd8);
        repeat (20) @(negedge clk);
        #1;
        check("bp_reads", ren_log.size(), 4);
        check("bp_valid", pe_cfg_valid, 1);
        ready_mode = 1;
        wait_idle(100);
        check("bp_deliv", deliv, 8);
        check("bp_words_sent", words_sent, 8);
        check("bp_done_cnt", done_cnt, 1);

        // Zero-length load.
        do_start(32'h500, 16'd0);
        wait_idle(10);
        check("zero_nreads", ren_log.size(), 0);
        check("zero_done_cycle", done_cyc - start_cyc, 1);
        check("zero_done_cnt", done_cnt, 1);

        // Address wrap and base alignment.
        do_start(32'hFFFF_FFF8, 16'd2);
        wait_idle(30);
        check("wrap_nreads", ren_log.size(), 2);
        if (ren_log.size() == 2) begin
            check("wrap_addr0", ren_log[0], 32'hFFFF_FFF8);
            check("wrap_addr1", ren_log[1], 32'h0000_0000);
        end
        do_start(32'h103, 16'd1);
        wait_idle(30);
        check("align_nreads", ren_log.size(), 1);
        if (ren_log.size() == 1) check("align_addr", ren_log[0], 32'h100);

        // Abort two cycles into an 8-word load.
        do_start(32'h600, 16'd8);
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        wait_idle(20);
        check("abort_reads", ren_log.size() <= 2, 1);
        check("abort_no_done", done_cnt, 0);
        check("abort_valid", pe_cfg_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_words_sent", words_sent, 0);

        // Reset during FETCH with two words buffered.
        ready_mode = 0;
        do_start(32'h700, 16'd8);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_outputs", {cfg_addr, cfg_ren, pe_cfg_valid, busy, done, words_sent}, '0);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        ready_mode = 1;
        do_start(32'h800, 16'd3);
        wait_idle(40);
        check("post_reset_deliv", deliv, 3);
        check("post_reset_words_sent", words_sent, 3);
        check("post_reset_done", done_cnt, 1);

`ifdef CGRA_CFG_PARITY_EN
        // Third word has odd parity.
        bad_en   = 1'b1;
        bad_addr = 32'h910;
        do_start(32'h900, 16'd4);
        wait_idle(30);
        bad_en = 1'b0;
        check("par_deliv", deliv, 2);
        check("par_words_sent", words_sent, 2);
        check("par_flag", parity_err, 1);
        check("par_addr", err_addr, 32'h910);
        check("par_no_done", done_cnt, 0);
        check("par_valid", pe_cfg_valid, 0);
`endif

        // Randomized loads with random backpressure, aborts and stray starts.
        ready_mode = 2;
        for (int t = 0; t < 40; t++) begin
            b = $urandom;
            if ($urandom_range(0, 3) != 0) b[2:0] = 3'b000;
            if ($urandom_range(0, 7) == 0) b = 32'hFFFF_FFC0 | (b & 32'h3F);
            n = 16'($urandom_range(0, 12));
            do_start(b, n);
            case ($urandom_range(0, 3))
                0: begin
                    repeat ($urandom_range(0, 12)) @(posedge clk);
                    #1 abort = 1'b1;
                    @(posedge clk);
                    #1 abort = 1'b0;
                end
                1: begin
                    repeat ($urandom_range(0, 6)) @(posedge clk);
                    #1 base_addr = $urandom;
                    num_words = 16'($urandom_range(1, 5));
                    start = 1'b1;
                    @(posedge clk);
                    #1 start = 1'b0;
                end
                default: ;
            endcase
            wait_idle(300);
            if ($urandom_range(0, 1) == 1) wait_idle(300);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
